// File: rtl/rs_issue_ctrl.sv
// ---------------------------------------------------------------------------
// rs_issue_ctrl
//   Tag/ready bookkeeping and issue scheduler for one reservation station.
//   Each slot holds two source rename tags plus their ready bits. Result
//   broadcasts wake pending sources. One fully-ready slot per cycle is
//   presented to the execution unit over a valid/ready handshake. No operand
//   data is stored here; the RS data array uses alloc_entry_o as its write
//   index and issue_entry_o as its read index.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   kill_i                  flush: invalidate every slot, return FSM to IDLE
//   alloc_valid_i           dispatch requests a slot
//   alloc_src{1,2}_i        source rename tags of the dispatched instruction
//   alloc_src{1,2}_rdy_i    source already resolved at dispatch
//   alloc_ready_o           at least one slot is free
//   alloc_entry_o           lowest free slot (written on alloc handshake)
//   exe_valid_i/exe_dst_i   per-port result broadcast (port k at [k*RRF_SEL +: RRF_SEL])
//   issue_valid_o           a ready slot is presented
//   issue_entry_o           presented slot index
//   issue_ready_i           execution unit accepts the presented slot
//   busy_o                  per-slot occupied vector
//   free_cnt_o              registered number of free slots
// ---------------------------------------------------------------------------
module rs_issue_ctrl #(
    parameter int ENTRY_NUM = 8,
    parameter int ENTRY_SEL = 3,
    parameter int RRF_SEL   = 6,
    parameter int EXE_NUM   = 5
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       kill_i,
    input  logic                       alloc_valid_i,
    input  logic [RRF_SEL-1:0]         alloc_src1_i,
    input  logic                       alloc_src1_rdy_i,
    input  logic [RRF_SEL-1:0]         alloc_src2_i,
    input  logic                       alloc_src2_rdy_i,
    output logic                       alloc_ready_o,
    output logic [ENTRY_SEL-1:0]       alloc_entry_o,
    input  logic [EXE_NUM-1:0]         exe_valid_i,
    input  logic [EXE_NUM*RRF_SEL-1:0] exe_dst_i,
    output logic                       issue_valid_o,
    output logic [ENTRY_SEL-1:0]       issue_entry_o,
    input  logic                       issue_ready_i,
    output logic [ENTRY_NUM-1:0]       busy_o,
    output logic [ENTRY_SEL:0]         free_cnt_o
);

    localparam logic [ENTRY_SEL:0] ALL_FREE = ENTRY_NUM[ENTRY_SEL:0];

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Wake match of one tag against every valid broadcast port.
    function automatic logic tag_hit(
        input logic [RRF_SEL-1:0]         tag,
        input logic [EXE_NUM-1:0]         vld,
        input logic [EXE_NUM*RRF_SEL-1:0] dst
    );
        logic h;
        h = 1'b0;
        for (int k = 0; k < EXE_NUM; k++) begin
            if (vld[k] && (dst[k*RRF_SEL +: RRF_SEL] == tag)) begin
                h = 1'b1;
            end
        end
        return h;
    endfunction

    function automatic logic [ENTRY_SEL:0] popcount(input logic [ENTRY_NUM-1:0] v);
        logic [ENTRY_SEL:0] c;
        c = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            c = c + {{ENTRY_SEL{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Slot state
    logic [ENTRY_NUM-1:0] busy;
    logic [ENTRY_NUM-1:0] rdy1;
    logic [ENTRY_NUM-1:0] rdy2;
    logic [RRF_SEL-1:0]   tag1 [ENTRY_NUM];
    logic [RRF_SEL-1:0]   tag2 [ENTRY_NUM];

    // Scheduler state
    state_t               state;
    state_t               state_nxt;
    logic [ENTRY_SEL-1:0] lock;
    logic [ENTRY_SEL:0]   free_cnt;

    // Combinational helpers
    logic [ENTRY_NUM-1:0] cand;
    logic                 cand_any;
    logic [ENTRY_SEL-1:0] pick;
    logic [ENTRY_SEL-1:0] free_pick;
    logic                 alloc_fire;
    logic                 accept;
    logic [ENTRY_NUM-1:0] alloc_oh;
    logic [ENTRY_NUM-1:0] issue_oh;
    logic [ENTRY_NUM-1:0] busy_nxt;
    logic [ENTRY_NUM-1:0] wake1;
    logic [ENTRY_NUM-1:0] wake2;
    logic                 alloc_hit1;
    logic                 alloc_hit2;

    assign cand     = busy & rdy1 & rdy2;
    assign cand_any = |cand;

    // Lowest-index ready slot and lowest-index free slot.
    always_comb begin
        pick      = '0;
        free_pick = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (cand[i]) begin
                pick = ENTRY_SEL'(i);
            end
            if (!busy[i]) begin
                free_pick = ENTRY_SEL'(i);
            end
        end
    end

    assign alloc_ready_o = |(~busy);
    assign alloc_entry_o = free_pick;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;

    // Once a slot has been offered and refused, keep offering that same slot
    // until it is taken, even if a lower-index slot becomes ready meanwhile.
    always_comb begin
        state_nxt     = state;
        issue_valid_o = 1'b0;
        issue_entry_o = pick;
        case (state)
            IDLE: begin
                issue_valid_o = cand_any;
                issue_entry_o = pick;
                if (cand_any && !issue_ready_i) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                issue_valid_o = 1'b1;
                issue_entry_o = lock;
                if (issue_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept = issue_valid_o && issue_ready_i;

    always_comb begin
        alloc_oh = '0;
        issue_oh = '0;
        wake1    = '0;
        wake2    = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            alloc_oh[i] = alloc_fire && (alloc_entry_o == ENTRY_SEL'(i));
            issue_oh[i] = accept && (issue_entry_o == ENTRY_SEL'(i));
            wake1[i]    = tag_hit(tag1[i], exe_valid_i, exe_dst_i);
            wake2[i]    = tag_hit(tag2[i], exe_valid_i, exe_dst_i);
        end
    end

    // Same-cycle bypass so a broadcast coinciding with dispatch is not lost.
    assign alloc_hit1 = tag_hit(alloc_src1_i, exe_valid_i, exe_dst_i);
    assign alloc_hit2 = tag_hit(alloc_src2_i, exe_valid_i, exe_dst_i);

    // Alloc targets a free slot and issue a busy one, so the masks never overlap.
    always_comb begin
        if (reset_i || kill_i) begin
            busy_nxt = '0;
        end else begin
            busy_nxt = (busy & ~issue_oh) | alloc_oh;
        end
    end

    // Control state
    always_ff @(posedge clk_i) begin
        if (reset_i || kill_i) begin
            busy     <= '0;
            rdy1     <= '0;
            rdy2     <= '0;
            state    <= IDLE;
            free_cnt <= ALL_FREE;
        end else begin
            busy     <= busy_nxt;
            state    <= state_nxt;
            free_cnt <= popcount(~busy_nxt);
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (issue_oh[i]) begin
                    rdy1[i] <= 1'b0;
                    rdy2[i] <= 1'b0;
                end else if (alloc_oh[i]) begin
                    rdy1[i] <= alloc_src1_rdy_i | alloc_hit1;
                    rdy2[i] <= alloc_src2_rdy_i | alloc_hit2;
                end else if (busy[i]) begin
                    if (wake1[i]) begin
                        rdy1[i] <= 1'b1;
                    end
                    if (wake2[i]) begin
                        rdy2[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Tags and the held index are qualified by busy/state, so they need no reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (alloc_oh[i]) begin
                tag1[i] <= alloc_src1_i;
                tag2[i] <= alloc_src2_i;
            end
        end
        if (state == IDLE && state_nxt == HOLD) begin
            lock <= pick;
        end
    end

    assign busy_o     = busy;
    assign free_cnt_o = free_cnt;

endmodule
